// File: rtl/lif_sweep_scheduler.sv
// lif_sweep_scheduler: one shared LIF update datapath swept across N_NEURONS virtual neurons per tick.
// Optional per-neuron refractory counters are built when REFRACTORY_EN is defined.
module lif_sweep_scheduler #(
    parameter int unsigned N_NEURONS = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned VW        = 8,
    parameter int unsigned GAIN      = 20,
    parameter int unsigned SHIFT     = 3
`ifdef REFRACTORY_EN
    ,
    parameter int unsigned REFRAC    = 4
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [VW-1:0] thresh,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_data,
    output logic          spk_valid,
    input  logic          spk_ready,
    output logic [AW-1:0] spk_idx,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 18;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 last_c;
    logic [VW-1:0]        thr_q;

    logic [7:0]           i_mem [N_NEURONS];
    logic [VW-1:0]        v_mem [N_NEURONS];
    logic [7:0]           i_ld;
    logic [VW-1:0]        v_ld;
    logic [VW-1:0]        v_nxt_c;
    logic [VW-1:0]        v_wr_c;
    logic [DW-1:0]        drive_c;
    logic signed [SW-1:0] diff_c;
    logic signed [SW-1:0] sum_c;
    logic                 fire_c;
`ifdef REFRACTORY_EN
    localparam int unsigned RW = $clog2(REFRAC + 1);
    logic [RW-1:0]        r_mem [N_NEURONS];
    logic [RW-1:0]        r_ld;
    logic [RW-1:0]        r_wr_c;
`endif

    assign last_c = (idx_q == AW'(N_NEURONS - 1));

    // Shared leaky-integrate datapath; fire decision uses the loaded (old) voltage
    always_comb begin
        v_wr_c  = '0;
`ifdef REFRACTORY_EN
        r_wr_c  = '0;
`endif
        drive_c = DW'(i_ld) * DW'(GAIN);
        diff_c  = $signed(SW'(drive_c)) - $signed(SW'(v_ld));
        sum_c   = $signed(SW'(v_ld)) + (diff_c >>> SHIFT);
        if (sum_c[SW-1])
            v_nxt_c = '0;
        else if (|sum_c[SW-2:VW])
            v_nxt_c = '1;
        else
            v_nxt_c = sum_c[VW-1:0];
`ifdef REFRACTORY_EN
        fire_c = (r_ld == '0) && (v_ld >= thr_q);
        if (r_ld != '0)
            r_wr_c = RW'(r_ld - 1'b1);
        else if (fire_c)
            r_wr_c = RW'(REFRAC);
        else
            v_wr_c = v_nxt_c;
`else
        fire_c = (v_ld >= thr_q);
        if (!fire_c)
            v_wr_c = v_nxt_c;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: if (tick) begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
            S_LOAD: state_d = S_CALC;
            S_CALC: begin
                if (fire_c) begin
                    state_d = S_EMIT;
                end else if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    idx_d   = AW'(idx_q + 1'b1);
                end
            end
            S_EMIT: if (spk_ready) begin
                if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    idx_d   = AW'(idx_q + 1'b1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            thr_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spk_valid <= 1'b0;
            spk_idx   <= '0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy      <= (state_d == S_LOAD) || (state_d == S_CALC) || (state_d == S_EMIT);
            done      <= (state_d == S_DONE);
            spk_valid <= (state_d == S_EMIT);
            if (state_d == S_EMIT)
                spk_idx <= idx_q;
            if (state_q == S_IDLE && tick)
                thr_q <= thresh;
            if (state_q != S_IDLE && tick)
                overrun <= 1'b1;
        end
    end

    // Per-neuron state arrays and the LOAD pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(N_NEURONS); k++) begin
                i_mem[k] <= '0;
                v_mem[k] <= '0;
`ifdef REFRACTORY_EN
                r_mem[k] <= '0;
`endif
            end
            i_ld <= '0;
            v_ld <= '0;
`ifdef REFRACTORY_EN
            r_ld <= '0;
`endif
        end else begin
            if (cfg_we && (32'(cfg_addr) < N_NEURONS))
                i_mem[cfg_addr] <= cfg_data;
            if (state_q == S_LOAD) begin
                i_ld <= i_mem[idx_q];
                v_ld <= v_mem[idx_q];
`ifdef REFRACTORY_EN
                r_ld <= r_mem[idx_q];
`endif
            end
            if (state_q == S_CALC) begin
                v_mem[idx_q] <= v_wr_c;
`ifdef REFRACTORY_EN
                r_mem[idx_q] <= r_wr_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Randomized bench for lif_sweep_scheduler against a per-neuron arithmetic reference model.
`timescale 1ns/1ps
module tb_lif_sweep_scheduler;
    localparam int N      = 16;
    localparam int AW     = 4;
    localparam int VW     = 8;
    localparam int GAIN   = 20;
    localparam int SHIFT  = 3;
    localparam int REFRAC = 4;
    localparam int VMAX   = (1 << VW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [VW-1:0] thresh;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_data;
    logic          spk_valid;
    logic          spk_ready;
    logic [AW-1:0] spk_idx;
    logic          busy;
    logic          done;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    int m_v [N];
    int m_i [N];
    int m_r [N];
    int exp_spk [$];
    int last_got [$];

    always #5 clk = ~clk;

    lif_sweep_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .thresh   (thresh),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .spk_valid(spk_valid),
        .spk_ready(spk_ready),
        .spk_idx  (spk_idx),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_v[n] = 0;
            m_i[n] = 0;
            m_r[n] = 0;
        end
    endtask

    // One tick's worth of neuron updates in index order, collecting expected spikes
    task automatic model_sweep(input int th);
        int nv;
        exp_spk.delete();
        for (int n = 0; n < N; n++) begin
            if (m_r[n] > 0) begin
                m_v[n] = 0;
                m_r[n] = m_r[n] - 1;
            end else if (m_v[n] >= th) begin
                exp_spk.push_back(n);
                m_v[n] = 0;
`ifdef REFRACTORY_EN
                m_r[n] = REFRAC;
`endif
            end else begin
                nv = m_v[n] + floor_div(m_i[n] * GAIN - m_v[n], 1 << SHIFT);
                m_v[n] = (nv < 0) ? 0 : ((nv > VMAX) ? VMAX : nv);
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        tick      = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        spk_ready = 1'b0;
        thresh    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = 8'(d);
        m_i[a]   = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Starts one sweep, watches it to done, compares against the model
    task automatic run_sweep(input int th, input int stall_pct, input int hold,
                             input int extra_tick, input bit with_cfg);
        int cyc, lat, bad_busy, bad_hold, a;
        bit pend;
        int held;
        lat = -1; bad_busy = 0; bad_hold = 0; pend = 1'b0; held = 0;
        last_got.delete();
        if (with_cfg) begin
            a        = $urandom_range(0, N - 1);
            cfg_we   = 1'b1;
            cfg_addr = AW'(a);
            cfg_data = 8'($urandom_range(0, 255));
            m_i[a]   = int'(cfg_data);
        end
        model_sweep(th);
        tick   = 1'b1;
        thresh = VW'(th);
        @(posedge clk);
        #1;
        tick      = 1'b0;
        cfg_we    = 1'b0;
        thresh    = VW'($urandom);
        spk_ready = (hold >= 1) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
        cyc = 1;
        while (cyc <= 2000) begin
            @(negedge clk);
            if (pend && (!spk_valid || int'(spk_idx) != held)) bad_hold++;
            if (!done && !busy) bad_busy++;
            if (done && busy) bad_busy++;
            if (spk_valid && spk_ready) begin
                last_got.push_back(int'(spk_idx));
                pend = 1'b0;
            end else if (spk_valid) begin
                pend = 1'b1;
                held = int'(spk_idx);
            end
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
            spk_ready = (cyc + 1 <= hold) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
            tick      = (cyc + 1 == extra_tick);
            cyc++;
        end
        check_eq("done_seen", int'(lat >= 0), 1);
        if (stall_pct == 0 && hold == 0)
            check_eq("done_latency", lat, 2 * N + 1 + exp_spk.size());
        check_eq("spike_count", last_got.size(), exp_spk.size());
        for (int k = 0; k < last_got.size() && k < exp_spk.size(); k++)
            check_eq($sformatf("spike_idx[%0d]", k), last_got[k], exp_spk[k]);
        check_eq("busy_shape", bad_busy, 0);
        check_eq("spk_hold", bad_hold, 0);
        for (int n = 0; n < N; n++)
            check_eq($sformatf("v[%0d]", n), int'(dut.v_mem[n]), m_v[n]);
        @(posedge clk);
        #1 spk_ready = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", int'(done), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input int ncyc);
        int act;
        act = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (busy || done || spk_valid) act++;
        end
        check_eq(tag, act, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_v3 [6];
        int seen;
        exp_v3 = '{2, 4, 6, 7, 8, 0};

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("rst_spk_valid", int'(spk_valid), 0);
        check_eq("rst_spk_idx", int'(spk_idx), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;

        // Single slow integrator reaching threshold on the sixth sweep
        cfg_write(3, 1);
        for (int s = 0; s < 6; s++) begin
            run_sweep(8, 0, 0, 0, 1'b0);
            check_eq($sformatf("v3_sweep%0d", s + 1), int'(dut.v_mem[3]), exp_v3[s]);
            check_eq($sformatf("v3_spikes%0d", s + 1), last_got.size(), (s == 5) ? 1 : 0);
        end
        check_eq("v3_spike_idx", (last_got.size() > 0) ? last_got[0] : -1, 3);

        // Silent sweep: exact latency, no events
        do_reset();
        run_sweep($urandom_range(1, 255), 0, 0, 0, 1'b0);
        check_eq("silent_spikes", last_got.size(), 0);

        // Backpressure: downstream holds off, events must stay put and come in order
        do_reset();
        cfg_write(0, 255);
        cfg_write(5, 255);
        run_sweep(0, 0, 14, 0, 1'b0);
        check_eq("stall_first_idx", (last_got.size() > 0) ? last_got[0] : -1, 0);

        // Randomized sweeps with stalls, config writes and threshold churn
        do_reset();
        for (int s = 0; s < 24; s++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, N - 1), $urandom_range(0, 255));
            run_sweep($urandom_range(0, 80), ($urandom_range(0, 1) == 1) ? 35 : 0, 0, 0,
                      $urandom_range(0, 2) == 0);
        end

        // Tick mid-sweep: flagged, ignored, sticky until reset
        do_reset();
        cfg_write(7, 200);
        run_sweep(30, 0, 0, 7, 1'b0);
        check_eq("overrun_mid", int'(overrun), 1);
        check_quiet("no_second_sweep", 40);
        check_eq("overrun_sticky", int'(overrun), 1);
        do_reset();
        @(negedge clk);
        check_eq("overrun_cleared", int'(overrun), 0);
        @(posedge clk);
        #1;

        // Tick landing on the DONE cycle counts as overrun
        run_sweep(200, 0, 0, 2 * N + 1, 1'b0);
        check_eq("overrun_done", int'(overrun), 1);
        check_quiet("no_sweep_after_done_tick", 40);

        // Reset while an event is pending
        do_reset();
        cfg_write(0, 255);
        tick   = 1'b1;
        thresh = '0;
        @(posedge clk);
        #1 tick = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (spk_valid) seen = 1;
        end
        check_eq("emit_reached", seen, 1);
        reset = 1'b0;
        #1;
        check_eq("rst_emit_valid", int'(spk_valid), 0);
        check_eq("rst_emit_busy", int'(busy), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        run_sweep(0, 0, 0, 0, 1'b0);
        check_eq("restart_first_idx", (last_got.size() > 0) ? last_got[0] : -1, 0);

`ifdef REFRACTORY_EN
        // Refractory window after a spike
        begin
            int pat [8];
            int hit;
            pat = '{0, 1, 0, 0, 0, 0, 0, 1};
            do_reset();
            cfg_write(2, 255);
            for (int s = 0; s < 8; s++) begin
                run_sweep(8, 0, 0, 0, 1'b0);
                hit = 0;
                foreach (last_got[k]) if (last_got[k] == 2) hit = 1;
                check_eq($sformatf("refrac_sweep%0d", s + 1), hit, pat[s]);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
